// File: rtl/rpn_eval_ctrl.sv
// rpn_eval_ctrl: postfix (RPN) expression evaluator that drives an external
// operand stack. Tokens are ASCII digits, + - * (and / when the RPN_DIV_EN
// macro is defined), '=' as terminator and space as filler. Errors put the
// block in ERR until '=' arrives, then the stack is drained back to empty.
module rpn_eval_ctrl #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tok_valid,
  input  logic [7:0]    tok_data,
  output logic          tok_ready,
  output logic          stk_push_stb,
  output logic [DW-1:0] stk_push_dat,
  output logic          stk_pop_stb,
  input  logic [DW-1:0] stk_pop_dat,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          err
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [3:0] {
    IDLE, PUSH_D, POP_B, POP_A, EXEC, PUSH_R, POP_RES, ERR, DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        depth_q, depth_d;
  logic                 err_q, err_d;
  logic [DW-1:0]        push_dat_q, push_dat_d;
  logic [DW-1:0]        res_data_q, res_data_d;
  logic                 res_valid_q, res_valid_d;
  logic [1:0]           op_q, op_d;
  logic signed [DW-1:0] a_q, a_d;
  logic signed [DW-1:0] b_q, b_d;

  logic                 tok_digit, tok_op, tok_eq, tok_space;
  logic [1:0]           tok_opcode;
  logic [DW-1:0]        digit_val;
  logic                 div_by_zero;

  // Arithmetic core: wraps to DW bits; division truncates toward zero.
  function automatic logic signed [DW-1:0] alu_f(input logic [1:0] op,
                                                 input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    logic signed [DW-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
`ifdef RPN_DIV_EN
      default: r = (b == '0) ? '0 : a / b;
`else
      default: r = '0;
`endif
    endcase
    return r;
  endfunction

  // Maps an operator character onto the internal opcode.
  function automatic logic [1:0] opcode_f(input logic [7:0] t);
    case (t)
      8'd43:   return OP_ADD;
      8'd45:   return OP_SUB;
      8'd42:   return OP_MUL;
      default: return OP_DIV;
    endcase
  endfunction

  // Token classification; '/' is an operator only when the divider is built.
  always_comb begin
    tok_digit  = (tok_data >= 8'd48) && (tok_data <= 8'd57);
`ifdef RPN_DIV_EN
    tok_op     = (tok_data == 8'd43) || (tok_data == 8'd45) ||
                 (tok_data == 8'd42) || (tok_data == 8'd47);
`else
    tok_op     = (tok_data == 8'd43) || (tok_data == 8'd45) ||
                 (tok_data == 8'd42);
`endif
    tok_eq     = (tok_data == 8'd61);
    tok_space  = (tok_data == 8'd32);
    tok_opcode = opcode_f(tok_data);
    // '0'..'9' are 0x30..0x39, so the low nibble is the digit value
    digit_val  = {{(DW-4){1'b0}}, tok_data[3:0]};
`ifdef RPN_DIV_EN
    div_by_zero = (op_q == OP_DIV) && (b_q == '0);
`else
    div_by_zero = 1'b0;
`endif
  end

  // Next-state, stack strobes and datapath updates.
  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    err_d        = err_q;
    push_dat_d   = push_dat_q;
    res_data_d   = res_data_q;
    res_valid_d  = 1'b0;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    tok_ready    = 1'b0;
    stk_push_stb = 1'b0;
    stk_pop_stb  = 1'b0;
    case (state_q)
      IDLE: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          if (tok_digit) begin
            if (depth_q == DEPTH_C) begin
              err_d   = 1'b1;
              state_d = ERR;
            end else begin
              push_dat_d = digit_val;
              state_d    = PUSH_D;
            end
          end else if (tok_op) begin
            if (depth_q < TWO_C) begin
              err_d   = 1'b1;
              state_d = ERR;
            end else begin
              op_d    = tok_opcode;
              state_d = POP_B;
            end
          end else if (tok_eq) begin
            if (depth_q != ONE_C) begin
              err_d   = 1'b1;
              state_d = ERR;
            end else begin
              state_d = POP_RES;
            end
          end else if (!tok_space) begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      PUSH_D: begin
        stk_push_stb = 1'b1;
        depth_d      = depth_q + ONE_C;
        state_d      = IDLE;
      end
      POP_B: begin
        stk_pop_stb = 1'b1;
        b_d         = stk_pop_dat;
        depth_d     = depth_q - ONE_C;
        state_d     = POP_A;
      end
      POP_A: begin
        stk_pop_stb = 1'b1;
        a_d         = stk_pop_dat;
        depth_d     = depth_q - ONE_C;
        state_d     = EXEC;
      end
      EXEC: begin
        if (div_by_zero) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          push_dat_d = alu_f(op_q, a_q, b_q);
          state_d    = PUSH_R;
        end
      end
      PUSH_R: begin
        stk_push_stb = 1'b1;
        depth_d      = depth_q + ONE_C;
        state_d      = IDLE;
      end
      POP_RES: begin
        stk_pop_stb = 1'b1;
        res_data_d  = stk_pop_dat;
        res_valid_d = 1'b1;
        depth_d     = '0;
        state_d     = IDLE;
      end
      ERR: begin
        tok_ready = 1'b1;
        if (tok_valid && tok_eq) state_d = DRAIN;
      end
      DRAIN: begin
        if (depth_q != '0) begin
          stk_pop_stb = 1'b1;
          depth_d     = depth_q - ONE_C;
        end else begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      err_q       <= 1'b0;
      push_dat_q  <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      push_dat_q  <= push_dat_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Operand and opcode holding registers; only read after being loaded.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

  assign stk_push_dat = push_dat_q;
  assign res_data     = res_data_q;
  assign res_valid    = res_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_rpn_eval_ctrl.sv
// Testbench for rpn_eval_ctrl: models the external stack, feeds token strings
// from a vector table and checks results through a scoreboard queue.
module tb_rpn_eval_ctrl;
  localparam int DEPTH = 16;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          tok_valid;
  logic [7:0]    tok_data;
  logic          tok_ready;
  logic          stk_push_stb;
  logic [DW-1:0] stk_push_dat;
  logic          stk_pop_stb;
  logic [DW-1:0] stk_pop_dat;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          err;

  rpn_eval_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .tok_valid(tok_valid), .tok_data(tok_data), .tok_ready(tok_ready),
    .stk_push_stb(stk_push_stb), .stk_push_dat(stk_push_dat),
    .stk_pop_stb(stk_pop_stb), .stk_pop_dat(stk_pop_dat),
    .res_valid(res_valid), .res_data(res_data), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // external stack model
  logic [DW-1:0] mem [DEPTH];
  int            sp;
  logic          pend_push, pend_pop;
  logic [DW-1:0] pend_dat;
  assign stk_pop_dat = (sp > 0) ? mem[sp-1] : '0;

  // scoreboard and per-run counters
  logic [DW-1:0] sb_q [$];
  int            res_cnt, pops_err;
  bit            err_seen;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) sp <= 0;
    else begin
      if (pend_pop) sp <= sp - 1;
      if (pend_push) begin
        mem[sp] <= pend_dat;
        sp      <= sp + 1;
      end
    end
  end

  // mid-cycle monitor: captures strobes for the stack model and checks results
  always @(negedge clk) begin
    if (reset) begin
      pend_push <= 1'b0;
      pend_pop  <= 1'b0;
    end else begin
      pend_push <= stk_push_stb;
      pend_pop  <= stk_pop_stb;
      pend_dat  <= stk_push_dat;
      if (err) err_seen = 1'b1;
      if (stk_push_stb || stk_pop_stb)
        check("push_pop_exclusive", DW'(stk_push_stb & stk_pop_stb), '0);
      if (stk_pop_stb) begin
        check("pop_not_empty", DW'(sp > 0), DW'(1));
        if (err) pops_err++;
      end
      if (stk_push_stb) check("push_not_full", DW'(sp < DEPTH), DW'(1));
      if (res_valid) begin
        res_cnt++;
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got 0x%0h, expected no res_valid", res_data);
        end else begin
          check("res_data", res_data, sb_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] ch);
    int n = 0;
    tok_valid = 1'b1;
    tok_data  = ch;
    while (!tok_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) begin
      tests++; fails++;
      $display("FAIL tok_accept: tok_ready=0 after %0d cycles, expected 1", n);
    end
    @(negedge clk);
    tok_valid = 1'b0;
  endtask

  task automatic run_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(tok_ready && !err) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(tok_ready && !err)) begin
      tests++; fails++;
      $display("FAIL idle_timeout: tok_ready=%0b err=%0b, expected 1/0", tok_ready, err);
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    string         expr;
    bit            has_res;
    logic [DW-1:0] res;
    int            drain_pops;
  } vec_t;

  vec_t vecs [$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{"34+=",               1'b1, 32'd7,          0});
    vecs.push_back('{"52-3*=",             1'b1, 32'd9,          0});
    vecs.push_back('{"12-=",               1'b1, 32'hFFFF_FFFF,  0});
    vecs.push_back('{" 9 9* =",            1'b1, 32'd81,         0});
    vecs.push_back('{"99*9*=",             1'b1, 32'd729,        0});
    vecs.push_back('{"09-=",               1'b1, 32'hFFFF_FFF7,  0});
    vecs.push_back('{"+7=",                1'b0, 32'd0,          0});
    vecs.push_back('{"8=",                 1'b1, 32'd8,          0});
    vecs.push_back('{"12345678901234567=", 1'b0, 32'd0,          16});
    vecs.push_back('{"x5=",                1'b0, 32'd0,          0});
    vecs.push_back('{"56a=",               1'b0, 32'd0,          2});
    vecs.push_back('{"3+4=",               1'b0, 32'd0,          1});
`ifdef RPN_DIV_EN
    vecs.push_back('{"84/=",               1'b1, 32'd2,          0});
    vecs.push_back('{"50/=",               1'b0, 32'd0,          0});
    vecs.push_back('{"07-2/=",             1'b1, 32'hFFFF_FFFD,  0});
`else
    vecs.push_back('{"84/=",               1'b0, 32'd0,          2});
`endif

    // reset state
    reset = 1'b1; tok_valid = 1'b0; tok_data = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_res_valid", DW'(res_valid), '0);
    check("rst_res_data", res_data, '0);
    check("rst_push_stb", DW'(stk_push_stb), '0);
    check("rst_pop_stb", DW'(stk_pop_stb), '0);
    check("rst_push_dat", stk_push_dat, '0);
    check("rst_err", DW'(err), '0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tok_ready", DW'(tok_ready), DW'(1));

    // table-driven expressions
    foreach (vecs[k]) begin
      res_cnt = 0; pops_err = 0; err_seen = 1'b0;
      if (vecs[k].has_res) sb_q.push_back(vecs[k].res);
      run_str(vecs[k].expr);
      wait_idle();
      check({"res_count ", vecs[k].expr}, DW'(res_cnt), DW'(vecs[k].has_res));
      check({"err_seen ", vecs[k].expr}, DW'(err_seen), DW'(!vecs[k].has_res));
      check({"drain_pops ", vecs[k].expr}, DW'(pops_err), DW'(vecs[k].drain_pops));
      check({"sb_empty ", vecs[k].expr}, DW'(sb_q.size()), '0);
      check({"stack_empty ", vecs[k].expr}, DW'(sp), '0);
      check({"err_clear ", vecs[k].expr}, DW'(err), '0);
    end

    // operand push: strobe, value and hold-off of the next token
    res_cnt = 0;
    send(8'd53);
    check("pushd_stb", DW'(stk_push_stb), DW'(1));
    check("pushd_dat", stk_push_dat, DW'(5));
    check("pushd_ready_low", DW'(tok_ready), '0);
    sb_q.push_back(DW'(5));
    send(8'd61);
    wait_idle();
    check("pushd_res_count", DW'(res_cnt), DW'(1));

    // asynchronous reset while in EXEC, then recovery
    send(8'd51);
    send(8'd52);
    send(8'd42);
    check("popb_stb", DW'(stk_pop_stb), DW'(1));
    @(negedge clk);
    check("popa_stb", DW'(stk_pop_stb), DW'(1));
    @(negedge clk);
    check("exec_no_pop", DW'(stk_pop_stb), '0);
    check("exec_no_push", DW'(stk_push_stb), '0);
    check("exec_res_data_pre", res_data, DW'(5));
    #1 reset = 1'b1;
    #1;
    check("arst_res_data", res_data, '0);
    check("arst_push_dat", stk_push_dat, '0);
    check("arst_push_stb", DW'(stk_push_stb), '0);
    check("arst_pop_stb", DW'(stk_pop_stb), '0);
    check("arst_res_valid", DW'(res_valid), '0);
    check("arst_err", DW'(err), '0);
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    res_cnt = 0;
    sb_q.push_back(DW'(9));
    run_str("9=");
    wait_idle();
    check("post_rst_res_count", DW'(res_cnt), DW'(1));
    check("post_rst_res_data", res_data, DW'(9));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
